// File: rtl/sobel_pkg.sv
// Shared types and width helpers for the Sobel gradient pipeline.
// The FLUSH state exists only when SOBEL_BORDER_REPLICATE_EN is defined.
package sobel_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_RUN
`ifdef SOBEL_BORDER_REPLICATE_EN
        , ST_FLUSH
`endif
    } state_t;

    localparam int MAG_SUM = 0;
    localparam int MAG_MAX = 1;

    localparam int DEF_PIX_W = 8;
    localparam int GRAD_W    = DEF_PIX_W + 3;
    localparam int ABS_W     = DEF_PIX_W + 2;

    // Gradients need 3 guard bits: weights sum to 4 and the result is signed.
    function automatic int grad_w(input int pix_w);
        return pix_w + 3;
    endfunction

    function automatic int abs_w(input int pix_w);
        return pix_w + 2;
    endfunction

endpackage

// File: rtl/sobel_kernel.sv
// Combinational 3x3 Sobel kernel producing signed Ix/Iy from a column window.
module sobel_kernel
    import sobel_pkg::*;
#(
    parameter int PIX_W = 8
) (
    input  logic [3*PIX_W-1:0] l_col,
    input  logic [PIX_W-1:0]   c_top,
    input  logic [PIX_W-1:0]   c_bot,
    input  logic [3*PIX_W-1:0] r_col,
    output logic [PIX_W+2:0]   ix,
    output logic [PIX_W+2:0]   iy
);

    localparam int GW = grad_w(PIX_W);

    logic signed [GW-1:0] lt, lm, lb, ct, cb, rt, rm, rb;
    logic signed [GW-1:0] ix_s, iy_s;

    assign lt = signed'(GW'(l_col[PIX_W-1:0]));
    assign lm = signed'(GW'(l_col[2*PIX_W-1:PIX_W]));
    assign lb = signed'(GW'(l_col[3*PIX_W-1:2*PIX_W]));
    assign ct = signed'(GW'(c_top));
    assign cb = signed'(GW'(c_bot));
    assign rt = signed'(GW'(r_col[PIX_W-1:0]));
    assign rm = signed'(GW'(r_col[2*PIX_W-1:PIX_W]));
    assign rb = signed'(GW'(r_col[3*PIX_W-1:2*PIX_W]));

    assign ix_s = (rt - lt) + ((rm - lm) <<< 1) + (rb - lb);
    assign iy_s = (lt - lb) + ((ct - cb) <<< 1) + (rt - rb);

    assign ix = ix_s;
    assign iy = iy_s;

endmodule

// File: rtl/sobel_grad_pipe.sv
// Streaming Sobel gradient pipeline: column window -> S1 gradients -> S2 magnitude.
// Define SOBEL_BORDER_REPLICATE_EN to replicate edge columns so each line yields IMG_W outputs.
module sobel_grad_pipe
    import sobel_pkg::*;
#(
    parameter int PIX_W    = 8,
    parameter int IMG_W    = 640,
    parameter int MAG_MODE = MAG_SUM
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clken,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     sol,
    input  logic [3*PIX_W-1:0]       col_in,
    output logic                     out_valid,
    output logic [PIX_W+2:0]         Ix,
    output logic [PIX_W+2:0]         Iy,
    output logic [PIX_W+2:0]         Ig,
    output logic [$clog2(IMG_W)-1:0] out_x,
    output logic                     line_err
);

    localparam int GW  = grad_w(PIX_W);
    localparam int AW  = abs_w(PIX_W);
    localparam int CW  = $clog2(IMG_W);
    localparam int CDW = 3 * PIX_W;
    localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
`ifdef SOBEL_BORDER_REPLICATE_EN
    localparam logic [CW-1:0] FILL_LAST = CW'(1);
`else
    localparam logic [CW-1:0] FILL_LAST = CW'(2);
`endif

    state_t               state, state_n;
    logic [CW-1:0]        col_cnt;
    logic [CDW-1:0]       win_l, win_c, win_r;
    logic                 win_vld;
    logic [CW-1:0]        win_x;
    logic [GW-1:0]        k_ix, k_iy;
    logic signed [GW-1:0] s1_ix, s1_iy;
    logic                 s1_vld;
    logic [CW-1:0]        s1_x;
    logic [AW-1:0]        abs_x, abs_y;
    logic [GW-1:0]        mag;
    logic                 accept, load_sol, shift, produce, drop;
`ifdef SOBEL_BORDER_REPLICATE_EN
    logic                 replicate;

    assign in_ready = (state != ST_FLUSH);
`else
    assign in_ready = 1'b1;
`endif

    assign accept = in_valid & in_ready & clken;

    always_comb begin
        state_n   = state;
        load_sol  = 1'b0;
        shift     = 1'b0;
        produce   = 1'b0;
        drop      = 1'b0;
`ifdef SOBEL_BORDER_REPLICATE_EN
        replicate = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (sol) begin
                        load_sol = 1'b1;
                        state_n  = ST_FILL;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            ST_FILL, ST_RUN: begin
                if (accept) begin
                    if (sol) begin
                        load_sol = 1'b1;
                        state_n  = ST_FILL;
                    end else begin
                        shift   = 1'b1;
                        produce = (state == ST_RUN) || (col_cnt == FILL_LAST);
                        if (col_cnt == LAST_COL) begin
`ifdef SOBEL_BORDER_REPLICATE_EN
                            state_n = ST_FLUSH;
`else
                            state_n = ST_IDLE;
`endif
                        end else if (produce) begin
                            state_n = ST_RUN;
                        end
                    end
                end
            end
`ifdef SOBEL_BORDER_REPLICATE_EN
            // The last column is shifted in a second time to centre the window on it.
            ST_FLUSH: begin
                if (clken) begin
                    replicate = 1'b1;
                    produce   = 1'b1;
                    state_n   = ST_IDLE;
                end
            end
`endif
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            col_cnt  <= '0;
            win_l    <= '0;
            win_c    <= '0;
            win_r    <= '0;
            win_vld  <= 1'b0;
            win_x    <= '0;
            line_err <= 1'b0;
        end else if (clken) begin
            state    <= state_n;
            line_err <= drop;
            win_vld  <= produce;
            if (load_sol) begin
                col_cnt <= CW'(1);
`ifdef SOBEL_BORDER_REPLICATE_EN
                win_l   <= col_in;
                win_c   <= col_in;
`endif
                win_r   <= col_in;
            end else if (shift) begin
                col_cnt <= col_cnt + CW'(1);
                win_l   <= win_c;
                win_c   <= win_r;
                win_r   <= col_in;
            end
`ifdef SOBEL_BORDER_REPLICATE_EN
            else if (replicate) begin
                win_l <= win_c;
                win_c <= win_r;
            end
            win_x <= replicate ? LAST_COL : col_cnt - CW'(1);
`else
            win_x <= col_cnt - CW'(1);
`endif
        end
    end

    sobel_kernel #(.PIX_W(PIX_W)) u_kernel (
        .l_col (win_l),
        .c_top (win_c[PIX_W-1:0]),
        .c_bot (win_c[CDW-1:2*PIX_W]),
        .r_col (win_r),
        .ix    (k_ix),
        .iy    (k_iy)
    );

    always_comb begin
        abs_x = s1_ix[GW-1] ? AW'(-s1_ix) : AW'(s1_ix);
        abs_y = s1_iy[GW-1] ? AW'(-s1_iy) : AW'(s1_iy);
        if (MAG_MODE == MAG_MAX) begin
            mag = (abs_x >= abs_y) ? GW'(abs_x) : GW'(abs_y);
        end else begin
            mag = GW'(abs_x) + GW'(abs_y);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_ix     <= '0;
            s1_iy     <= '0;
            s1_vld    <= 1'b0;
            s1_x      <= '0;
            Ix        <= '0;
            Iy        <= '0;
            Ig        <= '0;
            out_x     <= '0;
            out_valid <= 1'b0;
        end else if (clken) begin
            s1_ix     <= k_ix;
            s1_iy     <= k_iy;
            s1_vld    <= win_vld;
            s1_x      <= win_x;
            Ix        <= s1_ix;
            Iy        <= s1_iy;
            Ig        <= mag;
            out_x     <= s1_x;
            out_valid <= s1_vld;
        end
    end

endmodule

// File: tb/tb_sobel_grad_pipe.sv
// Self-checking bench for sobel_grad_pipe: window vector table plus a line-level reference model.
// Honours SOBEL_BORDER_REPLICATE_EN when the design is built with it.
module tb_sobel_grad_pipe;

    localparam int PIX_W = 8;
    localparam int IMG_W = 8;
    localparam int XW    = $clog2(IMG_W);
`ifdef SOBEL_BORDER_REPLICATE_EN
    localparam int OUT_PER_LINE = IMG_W;
`else
    localparam int OUT_PER_LINE = IMG_W - 2;
`endif

    logic              clk = 1'b0;
    logic              rst, clken, in_valid, sol;
    logic [3*PIX_W-1:0] col_in;
    logic              in_ready_a, out_valid_a, line_err_a;
    logic              in_ready_b, out_valid_b, line_err_b;
    logic [PIX_W+2:0]  ix_a, iy_a, ig_a, ix_b, iy_b, ig_b;
    logic [XW-1:0]     out_x_a, out_x_b;

    always #5 clk = ~clk;

    sobel_grad_pipe #(.PIX_W(PIX_W), .IMG_W(IMG_W), .MAG_MODE(0)) dut_a (
        .clk(clk), .rst(rst), .clken(clken), .in_valid(in_valid), .in_ready(in_ready_a),
        .sol(sol), .col_in(col_in), .out_valid(out_valid_a), .Ix(ix_a), .Iy(iy_a),
        .Ig(ig_a), .out_x(out_x_a), .line_err(line_err_a)
    );

    sobel_grad_pipe #(.PIX_W(PIX_W), .IMG_W(IMG_W), .MAG_MODE(1)) dut_b (
        .clk(clk), .rst(rst), .clken(clken), .in_valid(in_valid), .in_ready(in_ready_b),
        .sol(sol), .col_in(col_in), .out_valid(out_valid_b), .Ix(ix_b), .Iy(iy_b),
        .Ig(ig_b), .out_x(out_x_b), .line_err(line_err_b)
    );

    typedef struct {
        int x;
        int ix;
        int iy;
        int ig0;
        int ig1;
    } exp_t;

    typedef struct {
        string       name;
        logic [23:0] l;
        logic [23:0] c;
        logic [23:0] r;
        int          ix;
        int          iy;
        int          ig0;
        int          ig1;
    } vec_t;

    exp_t        expq[$];
    logic [23:0] cols[$];
    bit          active   = 1'b0;
    bit          rand_en  = 1'b0;
    int          tests    = 0;
    int          fails    = 0;
    int          n_out    = 0;
    int          seen_err = 0;
    int          exp_err  = 0;
    bit          got1     = 1'b0;
    int          t_ix, t_iy, t_ig0, t_ig1;
    bit          mon_en;
    exp_t        mon_e;

    task automatic check_output(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int px(input logic [23:0] c, input int row);
        return int'(c[row*8 +: 8]);
    endfunction

    function automatic logic [23:0] mkcol(input int t, input int m, input int b);
        return {8'(b), 8'(m), 8'(t)};
    endfunction

    // Reference: Sobel gradients and magnitudes from plain integer arithmetic.
    function automatic exp_t window(input logic [23:0] l, input logic [23:0] c,
                                    input logic [23:0] r, input int x);
        exp_t e;
        int   ax, ay;
        e.x   = x;
        e.ix  = (px(r, 0) - px(l, 0)) + 2 * (px(r, 1) - px(l, 1)) + (px(r, 2) - px(l, 2));
        e.iy  = (px(l, 0) - px(l, 2)) + 2 * (px(c, 0) - px(c, 2)) + (px(r, 0) - px(r, 2));
        ax    = (e.ix < 0) ? -e.ix : e.ix;
        ay    = (e.iy < 0) ? -e.iy : e.iy;
        e.ig0 = ax + ay;
        e.ig1 = (ax > ay) ? ax : ay;
        return e;
    endfunction

    function automatic vec_t mkvec(input string n, input logic [23:0] l, input logic [23:0] c,
                                   input logic [23:0] r, input int ix, input int iy,
                                   input int ig0, input int ig1);
        vec_t v;
        v.name = n; v.l = l; v.c = c; v.r = r;
        v.ix = ix; v.iy = iy; v.ig0 = ig0; v.ig1 = ig1;
        return v;
    endfunction

    // Line-level model: a line is the list of columns since the last sol.
    function automatic void model_accept(input logic s, input logic [23:0] c);
        int n;
        if (s) begin
            cols.delete();
            cols.push_back(c);
            active = 1'b1;
        end else if (!active) begin
            exp_err++;
        end else begin
            cols.push_back(c);
            n = cols.size();
`ifdef SOBEL_BORDER_REPLICATE_EN
            if (n == 2) expq.push_back(window(cols[0], cols[0], cols[1], 0));
`endif
            if (n >= 3) expq.push_back(window(cols[n-3], cols[n-2], cols[n-1], n - 2));
            if (n == IMG_W) begin
`ifdef SOBEL_BORDER_REPLICATE_EN
                expq.push_back(window(cols[n-2], cols[n-1], cols[n-1], n - 1));
`endif
                active = 1'b0;
            end
        end
    endfunction

    task automatic apply_stimulus(input logic s, input logic [23:0] c);
        int guard;
        bit acc;
        in_valid = 1'b1;
        sol      = s;
        col_in   = c;
        guard    = 0;
        do begin
            clken = rand_en ? ($urandom_range(0, 3) != 0) : 1'b1;
            acc   = clken && in_ready_a && in_ready_b;
            @(negedge clk);
            guard++;
        end while (!acc && guard < 200);
        if (acc) model_accept(s, c);
        else check_output("accept_timeout", int'(acc), 1);
        in_valid = 1'b0;
        sol      = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        sol      = 1'b0;
        repeat (n) begin
            clken = rand_en ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(negedge clk);
        end
    endtask

    // Outputs only advance on clken edges, so each such edge carries at most one new result.
    always @(posedge clk) begin
        mon_en = clken && rst;
        #1;
        if (mon_en && rst) begin
            if (line_err_a || line_err_b) begin
                check_output("line_err_match", int'(line_err_b), int'(line_err_a));
                seen_err++;
            end
            if (out_valid_a || out_valid_b) begin
                check_output("valid_match", int'(out_valid_b), int'(out_valid_a));
                check_output("output_expected", int'(expq.size() > 0), 1);
                if (expq.size() > 0) begin
                    mon_e = expq.pop_front();
                    n_out++;
                    check_output("out_x", int'(out_x_a), mon_e.x);
                    check_output("ix", int'($signed(ix_a)), mon_e.ix);
                    check_output("iy", int'($signed(iy_a)), mon_e.iy);
                    check_output("ig_sum", int'(ig_a), mon_e.ig0);
                    check_output("ig_max", int'(ig_b), mon_e.ig1);
                    check_output("ix_b", int'($signed(ix_b)), mon_e.ix);
                    if (out_x_a == XW'(1)) begin
                        got1  = 1'b1;
                        t_ix  = int'($signed(ix_a));
                        t_iy  = int'($signed(iy_a));
                        t_ig0 = int'(ig_a);
                        t_ig1 = int'(ig_b);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t tbl[8];
        int   base, e0;
        bit   s;

        rst = 1'b0; clken = 1'b1; in_valid = 1'b0; sol = 1'b0; col_in = '0;
        repeat (3) @(negedge clk);
        check_output("rst_out_valid", int'(out_valid_a), 0);
        check_output("rst_line_err", int'(line_err_a), 0);
        check_output("rst_ix", int'(ix_a), 0);
        check_output("rst_iy", int'(iy_a), 0);
        check_output("rst_ig", int'(ig_a), 0);
        check_output("rst_out_x", int'(out_x_a), 0);
        rst = 1'b1;
        @(negedge clk);
        check_output("rst_in_ready", int'(in_ready_a), 1);

        tbl[0] = mkvec("flat", mkcol(100,100,100), mkcol(100,100,100), mkcol(100,100,100), 0, 0, 0, 0);
        tbl[1] = mkvec("ramp", mkcol(10,10,10), mkcol(20,20,20), mkcol(30,30,30), 80, 0, 80, 80);
        tbl[2] = mkvec("top_hi", mkcol(255,128,0), mkcol(255,128,0), mkcol(255,128,0), 0, 1020, 1020, 1020);
        tbl[3] = mkvec("left_right", mkcol(0,0,0), mkcol(77,77,77), mkcol(255,255,255), 1020, 0, 1020, 1020);
        tbl[4] = mkvec("mixed", mkcol(0,150,0), mkcol(100,33,0), mkcol(0,0,0), -300, 200, 500, 300);
        tbl[5] = mkvec("neg_iy", mkcol(0,50,255), mkcol(0,50,255), mkcol(0,50,255), 0, -1020, 1020, 1020);
        tbl[6] = mkvec("neg_ix", mkcol(255,255,255), mkcol(9,9,9), mkcol(0,0,0), -1020, 0, 1020, 1020);
        tbl[7] = mkvec("diag", mkcol(0,0,0), mkcol(255,255,0), mkcol(255,255,255), 1020, 510, 1530, 1020);

        for (int i = 0; i < 8; i++) begin
            got1 = 1'b0;
            apply_stimulus(1'b1, tbl[i].l);
            apply_stimulus(1'b0, tbl[i].c);
            apply_stimulus(1'b0, tbl[i].r);
            idle(6);
            check_output({tbl[i].name, "_seen"}, int'(got1), 1);
            if (got1) begin
                check_output({tbl[i].name, "_ix"}, t_ix, tbl[i].ix);
                check_output({tbl[i].name, "_iy"}, t_iy, tbl[i].iy);
                check_output({tbl[i].name, "_ig_sum"}, t_ig0, tbl[i].ig0);
                check_output({tbl[i].name, "_ig_max"}, t_ig1, tbl[i].ig1);
            end
        end

        base = n_out;
        for (int x = 0; x < IMG_W; x++) apply_stimulus(x == 0, mkcol(100, 100, 100));
        idle(6);
        check_output("flat_line_count", n_out - base, OUT_PER_LINE);

        base = n_out;
        for (int x = 0; x < IMG_W; x++) apply_stimulus(x == 0, mkcol(10 * x, 10 * x, 10 * x));
        idle(6);
        check_output("ramp_line_count", n_out - base, OUT_PER_LINE);

        for (int x = 0; x < 4; x++) apply_stimulus(x == 0, 24'($urandom));
        for (int x = 0; x < IMG_W; x++) apply_stimulus(x == 0, 24'($urandom));
        idle(6);

        e0 = seen_err;
        apply_stimulus(1'b0, 24'($urandom));
        idle(4);
        check_output("line_err_pulse", seen_err - e0, 1);

        rand_en = 1'b1;
        for (int ln = 0; ln < 12; ln++) begin
            for (int x = 0; x < IMG_W; x++) begin
                s = (x == 0) || (x >= 2 && x <= IMG_W - 2 && $urandom_range(0, 9) == 0);
                apply_stimulus(s, 24'($urandom));
                if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
            end
            if ($urandom_range(0, 2) == 0) apply_stimulus(1'b0, 24'($urandom));
            idle($urandom_range(0, 4));
        end

        for (int x = 0; x < 5; x++) apply_stimulus(x == 0, 24'($urandom));
        rst = 1'b0;
        expq.delete();
        cols.delete();
        active = 1'b0;
        repeat (2) @(negedge clk);
        check_output("midreset_out_valid", int'(out_valid_a), 0);
        check_output("midreset_in_ready", int'(in_ready_a), 1);
        rst = 1'b1;
        base = n_out;
        e0   = seen_err;
        apply_stimulus(1'b0, 24'($urandom));
        apply_stimulus(1'b0, 24'($urandom));
        idle(10);
        check_output("no_output_after_reset", n_out - base, 0);
        check_output("line_err_after_reset", seen_err - e0, 2);

        base = n_out;
        for (int x = 0; x < IMG_W; x++) apply_stimulus(x == 0, 24'($urandom));
        rand_en = 1'b0;
        idle(10);
        check_output("post_reset_line_count", n_out - base, OUT_PER_LINE);
        check_output("pending_outputs", expq.size(), 0);
        check_output("line_err_total", seen_err, exp_err);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
